// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel interval timer.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Prescaler division ratio; callers guarantee an integer result of at least 2.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM with an up/down counter and valid/ack result hold.
module timer_channel #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic             ack_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] count_o,
  output logic             ovf_o
);
  import timer_pkg::*;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        count_d = '0;
        ovf_d   = 1'b0;
        if (en_i) begin
          state_d = StRun;
          mode_d  = mode_i;
          count_d = (mode_i == MODE_DOWN) ? load_i : '0;
        end
      end
      StRun: begin
        // A stop wins over a coincident tick, so the count freezes where it is.
        if (!en_i) begin
          state_d = StDone;
        end else if (mode_q == MODE_DOWN) begin
          if (count_q == '0) begin
            state_d = StDone;
          end else if (tick_i) begin
            count_d = count_q - WIDTH'(1);
          end
        end else if (tick_i) begin
          count_d = count_q + WIDTH'(1);
          if (&count_q) begin
            ovf_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (ack_i) begin
          state_d = StIdle;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
        ovf_d   = 1'b0;
      end
    endcase
    // Registered so valid lines up with the frozen count.
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= MODE_UP;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel interval timer: one shared free-running prescaler feeding N_CH channels.
module timer_multi #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 10,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N_CH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       t_en,
  input  logic [N_CH-1:0]       t_mode,
  input  logic [WIDTH-1:0]      t_load,
  input  logic [N_CH-1:0]       t_ack,
  output logic [N_CH-1:0]       t_valid,
  output logic [N_CH*WIDTH-1:0] t_out,
  output logic [N_CH-1:0]       t_ovf
);
  import timer_pkg::*;

  localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  // Never restarted by channel activity, hence the +/-1 tick run-time resolution.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .en_i   (t_en[i]),
      .mode_i (t_mode[i]),
      .load_i (t_load),
      .ack_i  (t_ack[i]),
      .valid_o(t_valid[i]),
      .count_o(t_out[i*WIDTH +: WIDTH]),
      .ovf_o  (t_ovf[i])
    );
  end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi (DIV = 10, WIDTH = 4, two channels).
module tb_timer_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] t_en = '0;
  logic [1:0] t_mode = '0;
  logic [1:0] t_ack = '0;
  logic [3:0] t_load = '0;
  logic [1:0] t_valid;
  logic [7:0] t_out;
  logic [1:0] t_ovf;

  timer_multi #(
    .CLK_HZ (100),
    .TICK_HZ(10),
    .WIDTH  (4),
    .N_CH   (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .t_en   (t_en),
    .t_mode (t_mode),
    .t_load (t_load),
    .t_ack  (t_ack),
    .t_valid(t_valid),
    .t_out  (t_out),
    .t_ovf  (t_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_no = 0;

  // Reference model: phase 0 idle, 1 running, 2 result held; result derived from tick count.
  int m_phase[2];
  int m_ticks[2];
  int m_load[2];
  bit m_mode[2];

  function automatic int m_value(input int ch);
    if (m_phase[ch] == 0) return 0;
    if (m_mode[ch]) return m_load[ch] - m_ticks[ch];
    return m_ticks[ch] % 16;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_phase[c] = 0;
      m_ticks[c] = 0;
      m_load[c]  = 0;
      m_mode[c]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit tick;
    tick = (edge_no % 10 == 0);
    for (int c = 0; c < 2; c++) begin
      case (m_phase[c])
        0: if (t_en[c]) begin
          m_phase[c] = 1;
          m_ticks[c] = 0;
          m_mode[c]  = t_mode[c];
          m_load[c]  = int'(t_load);
        end
        1: begin
          if (!t_en[c]) m_phase[c] = 2;
          else if (m_mode[c] && m_value(c) == 0) m_phase[c] = 2;
          else if (tick) m_ticks[c]++;
        end
        default: if (t_ack[c]) begin
          m_phase[c] = 0;
          m_ticks[c] = 0;
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic check_all();
    logic [7:0] e_out;
    logic [1:0] e_valid;
    logic [1:0] e_ovf;
    for (int c = 0; c < 2; c++) begin
      e_out[c*4 +: 4] = 4'(m_value(c));
      e_valid[c]      = (m_phase[c] == 2);
      e_ovf[c]        = (m_phase[c] != 0) && !m_mode[c] && (m_ticks[c] >= 16);
    end
    chk("t_out", 32'(t_out), 32'(e_out));
    chk("t_valid", 32'(t_valid), 32'(e_valid));
    chk("t_ovf", 32'(t_ovf), 32'(e_ovf));
  endtask

  task automatic step(input logic [1:0] en, input logic [1:0] mode, input logic [1:0] ack,
                      input logic [3:0] load);
    t_en   = en;
    t_mode = mode;
    t_ack  = ack;
    t_load = load;
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out", 32'(t_out), 32'd0);
    chk("rst_valid", 32'(t_valid), 32'd0);
    chk("rst_ovf", 32'(t_ovf), 32'd0);
    t_en  = '0;
    t_ack = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_no = 0;
  endtask

  initial begin
    int g;
    logic [3:0] exp_cnt;
    logic [3:0] ld;
    model_reset();

    // Reset with all inputs low.
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Ch0 up for 35 clocks, then stop and hold before ack.
    for (int i = 0; i < 35; i++) step(2'b01, 2'b00, 2'b00, 4'd0);
    step(2'b00, 2'b00, 2'b00, 4'd0);
    chk("up35_valid", 32'(t_valid[0]), 32'd1);
    chk("up35_range", 32'(t_out[3:0] >= 4'd2 && t_out[3:0] <= 4'd4), 32'd1);
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 2'b00, 4'd0);
    step(2'b00, 2'b00, 2'b01, 4'd0);
    chk("up35_ack_out", 32'(t_out[3:0]), 32'd0);
    step(2'b00, 2'b00, 2'b00, 4'd0);

    // Ch0 up past wrap: 17 ticks.
    g = 0;
    step(2'b01, 2'b00, 2'b00, 4'd0);
    while (m_ticks[0] < 17 && g < 400) begin
      step(2'b01, 2'b00, 2'b00, 4'd0);
      g++;
    end
    step(2'b00, 2'b00, 2'b00, 4'd0);
    chk("wrap_out", 32'(t_out[3:0]), 32'd1);
    chk("wrap_ovf", 32'(t_ovf[0]), 32'd1);
    step(2'b00, 2'b00, 2'b01, 4'd0);
    chk("wrap_ovf_clr", 32'(t_ovf[0]), 32'd0);

    // Ch1 countdown from 3.
    step(2'b10, 2'b10, 2'b00, 4'd3);
    g = 0;
    while (!t_valid[1] && g < 60) begin
      step(2'b10, 2'b10, 2'b00, 4'd3);
      g++;
    end
    chk("cd3_valid", 32'(t_valid[1]), 32'd1);
    chk("cd3_out", 32'(t_out[7:4]), 32'd0);
    step(2'b00, 2'b00, 2'b10, 4'd0);

    // Countdown from 0 finishes two cycles after start without a tick.
    step(2'b10, 2'b10, 2'b00, 4'd0);
    chk("cd0_early", 32'(t_valid[1]), 32'd0);
    step(2'b10, 2'b10, 2'b00, 4'd0);
    chk("cd0_valid", 32'(t_valid[1]), 32'd1);
    step(2'b00, 2'b00, 2'b10, 4'd0);

    // Stop on the tick edge, then ack with enable still high.
    step(2'b01, 2'b00, 2'b00, 4'd0);
    for (int i = 0; i < 12; i++) step(2'b01, 2'b00, 2'b00, 4'd0);
    g = 0;
    while ((edge_no + 1) % 10 != 0 && g < 20) begin
      step(2'b01, 2'b00, 2'b00, 4'd0);
      g++;
    end
    exp_cnt = 4'(m_value(0));
    step(2'b00, 2'b00, 2'b00, 4'd0);
    chk("stop_tick", 32'(t_out[3:0]), 32'(exp_cnt));
    step(2'b01, 2'b00, 2'b01, 4'd0);
    chk("ack_en_idle", 32'(t_valid[0]), 32'd0);
    step(2'b01, 2'b00, 2'b00, 4'd0);
    for (int i = 0; i < 15; i++) step(2'b01, 2'b00, 2'b00, 4'd0);
    step(2'b00, 2'b00, 2'b00, 4'd0);
    step(2'b00, 2'b00, 2'b01, 4'd0);

    // Overlap: ch0 up, ch1 countdown acked while ch0 keeps running.
    ld = 4'($urandom_range(2, 6));
    step(2'b11, 2'b10, 2'b00, ld);
    g = 0;
    while (!t_valid[1] && g < 100) begin
      step(2'b11, 2'b10, 2'b00, ld);
      g++;
    end
    chk("ovl_cd_valid", 32'(t_valid[1]), 32'd1);
    step(2'b01, 2'b10, 2'b10, ld);
    chk("ovl_ch0_valid", 32'(t_valid[0]), 32'd0);
    for (int i = 0; i < 15; i++) step(2'b01, 2'b00, 2'b00, 4'd0);
    step(2'b00, 2'b00, 2'b00, 4'd0);
    step(2'b00, 2'b00, 2'b11, 4'd0);

    // Randomized soak.
    for (int i = 0; i < 800; i++) begin
      logic [1:0] en;
      en = t_en;
      for (int c = 0; c < 2; c++) if ($urandom_range(0, 11) == 0) en[c] = ~en[c];
      step(en, 2'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0), 4'($urandom));
    end

    // Reset in the middle of a run.
    step(2'b00, 2'b00, 2'b11, 4'd0);
    step(2'b00, 2'b00, 2'b00, 4'd0);
    for (int i = 0; i < 23; i++) step(2'b11, 2'b10, 2'b00, 4'd9);
    apply_reset();
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 2'b00, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_multi.md
# timer_multi

Parametrised multi-channel interval timer, the successor to the single 16-bit timer. One shared prescaler derives a tick from the fast system clock. Each of N_CH independent channels runs as a stopwatch (count up) or a countdown, and latches its result behind a valid/ack handshake. Consumers are the display and control logic, which read `t_out` when `t_valid` is high.

## Interface
- `CLK_HZ`, default 50_000_000: frequency of `clk`.
- `TICK_HZ`, default 10: count rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- `WIDTH`, default 16: counter width per channel.
- `N_CH`, default 4: number of channels.

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `t_en`, in, N_CH: per-channel run level. High starts or keeps running; low stops.
- `t_mode`, in, N_CH: per-channel mode, sampled on start. 0 = count up, 1 = countdown.
- `t_load`, in, WIDTH: countdown start value, shared by all channels, sampled on start.
- `t_ack`, in, N_CH: per-channel result acknowledge.
- `t_valid`, out, N_CH: result held on `t_out` slice is final.
- `t_out`, out, N_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH]; live count in every state.
- `t_ovf`, out, N_CH: sticky up-count wrap flag.

## Operation
- Prescaler:
  - Free-running counter 0..DIV-1 from reset.
  - `tick` is a 1-cycle pulse when the counter equals DIV-1.
  - Channels never restart it.
- Channel FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - count = 0, `t_valid` = 0, `t_ovf` = 0.
  - If `t_en[i]` = 1, go to RUN and latch the mode.
  - Count is loaded as 0 (up mode) or `t_load` (countdown).
- RUN, up mode:
  - On `tick`, count ← count + 1 modulo 2^WIDTH.
  - On the wrap from 2^WIDTH−1 to 0, set `t_ovf`.
- RUN, countdown mode:
  - On `tick` with count > 0, count ← count − 1.
  - When count = 0 (including `t_load` = 0), go to DONE on the next edge.
  - Never underflows.
- RUN to DONE when `t_en[i]` = 0.
  - A tick in that same cycle is discarded; the count freezes at its current value.
- DONE:
  - Count frozen, `t_valid` = 1, `t_en` ignored.
  - If `t_ack[i]` = 1, go to IDLE with count, `t_ovf` and `t_valid` cleared.
- Ack is only meaningful in DONE; it is ignored in IDLE and RUN.
- If `t_en` is still high when the ack is taken, the channel restarts one cycle later through IDLE.
- Channels are fully independent; simultaneous events on different channels never interact.

## Timing
- Reset values: `t_out` = 0, `t_valid` = 0, `t_ovf` = 0, all channels IDLE, prescaler = 0.
- Reset mid-run aborts immediately and asynchronously; no result is presented.
- All outputs are registered. No combinational path exists from any input to any output.
- Start: `t_en` high at edge k puts the channel in RUN after edge k. The first possible increment is the first tick at edge ≥ k+1.
- Stop: `t_en` low sampled at edge k raises `t_valid` after edge k. `t_out` is stable from then until the ack.
- Ack: `t_ack` high at edge k while in DONE drops `t_valid` and clears `t_out` after edge k.
- Countdown reaches 0 at edge k; `t_valid` rises after edge k+1.
- Tick period is exactly DIV clk cycles. Run-time resolution is ±1 tick, because the prescaler phase is not reset on start.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - mode constants MODE_UP = 0 and MODE_DOWN = 1;
  - a DIV computation function.
- Sub-module `timer_channel`:
  - one FSM plus its counter, parametrised by WIDTH;
  - instantiated N_CH times in a generate loop.
- The prescaler is inline in the top level and fans out `tick`.

## Test plan
Bench configuration: CLK_HZ = 100, TICK_HZ = 10 (DIV = 10), WIDTH = 4, N_CH = 2.
- Reset with all inputs 0 → every output 0. Assert `rst` mid-RUN → outputs 0 immediately, no `t_valid`.
- Ch0 up mode: `t_en[0]` high for 35 clk, then low → `t_valid[0]` = 1, `t_out[3:0]` = 3 (±1 per phase), held until `t_ack[0]`; cleared to 0 the cycle after the ack.
- Ch0 up mode held for 17 ticks → count wraps 15→0, final `t_out` = 1, `t_ovf[0]` = 1 until ack.
- Ch1 countdown, `t_load` = 3 → decrements 3,2,1,0; `t_valid[1]` rises 1 cycle after reaching 0, `t_out[7:4]` = 0. With `t_load` = 0 → `t_valid` 2 cycles after start, no tick needed.
- Stop edge coincident with tick → the tick is discarded and the count is unchanged. Ack with `t_en` still high → IDLE, then RUN restarts from 0.
- Both channels run overlapping with different modes; ch1 acked while ch0 runs → ch0 count unaffected, its `t_valid` stays 0.
